// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: walks enabled mux_4x1 channels, samples y after settling,
// and presents 4-bit frames on a valid/ready handshake with count/overrun.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-low reset
//   start, cont_mode    scan request (IDLE only) / rescan after each frame
//   ch_mask[3:0]        channel enables, latched at scan start
//   y                   registered mux output
//   s1, s0              mux select (current channel index)
//   frame[3:0]          sampled channels, masked bits 0
//   frame_valid/ready   frame handshake
//   busy                not IDLE
//   frame_cnt           frames loaded, wrapping
//   overrun             sticky dropped-frame flag
module mux_scan_ctrl #(
  parameter int SETTLE_CYC  = 2,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   cont_mode,
  input  logic [3:0]             ch_mask,
  input  logic                   y,
  output logic                   s1,
  output logic                   s0,
  output logic [3:0]             frame,
  output logic                   frame_valid,
  input  logic                   frame_ready,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   overrun
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    OUTPUT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [1:0] ch_q;
  logic [1:0] ch_d;
  logic [3:0] mask_q;
  logic [3:0] mask_d;
  logic [3:0] buf_q;
  logic [3:0] buf_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  logic [3:0]             frame_d;
  logic                   valid_d;
  logic                   ovr_d;
  logic                   busy_d;
  logic [FRAME_CNT_W-1:0] fcnt_d;

  logic       go;
  logic       settled;
  logic       rescan;
  logic       load;
  logic [2:0] nxt;
  logic [1:0] first_ch;

  function automatic logic [1:0] low_bit(
    input logic [3:0] m
  );
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  // {found, index} of the lowest set bit above c
  function automatic logic [2:0] next_bit(
    input logic [3:0] m,
    input logic [1:0] c
  );
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && i > int'(c)) begin
        r = {1'b1, 2'(i)};
      end
    end
    return r;
  endfunction

  assign go       = start && (ch_mask != 4'b0000);
  assign settled  = cnt_q == 4'(SETTLE_CYC - 1);
  assign rescan   = cont_mode && (ch_mask != 4'b0000);
  assign load     = !frame_valid || frame_ready;
  assign nxt      = next_bit(mask_q, ch_q);
  assign first_ch = low_bit(ch_mask);

  assign s1 = ch_q[1];
  assign s0 = ch_q[0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (go) state_d = SETTLE;
      end
      SETTLE: begin
        if (settled) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (nxt[2]) state_d = SETTLE;
        else        state_d = OUTPUT;
      end
      OUTPUT: begin
        if (rescan) state_d = SETTLE;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ch_d    = ch_q;
    mask_d  = mask_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    frame_d = frame;
    valid_d = frame_valid;
    fcnt_d  = frame_cnt;
    ovr_d   = overrun;
    busy_d  = state_d != IDLE;

    // plain accept; a load below overrides it
    if (frame_valid && frame_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (go) begin
          mask_d = ch_mask;
          ch_d   = first_ch;
          cnt_d  = 4'd0;
          ovr_d  = 1'b0;
          buf_d  = 4'b0000;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 4'd1;
      end
      SAMPLE: begin
        buf_d[ch_q] = y;
        if (nxt[2]) begin
          ch_d  = nxt[1:0];
          cnt_d = 4'd0;
        end
      end
      OUTPUT: begin
        if (load) begin
          frame_d = buf_q;
          valid_d = 1'b1;
          fcnt_d  = frame_cnt
                  + FRAME_CNT_W'(1);
        end else begin
          ovr_d = 1'b1;
        end
        if (rescan) begin
          mask_d = ch_mask;
          ch_d   = first_ch;
          cnt_d  = 4'd0;
          buf_d  = 4'b0000;
        end else begin
          ch_d = 2'd0;
        end
      end
      default: begin
        ch_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ch_q        <= 2'd0;
      mask_q      <= 4'b0000;
      buf_q       <= 4'b0000;
      cnt_q       <= 4'd0;
      frame       <= 4'b0000;
      frame_valid <= 1'b0;
      frame_cnt   <= '0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      ch_q        <= ch_d;
      mask_q      <= mask_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      frame       <= frame_d;
      frame_valid <= valid_d;
      frame_cnt   <= fcnt_d;
      overrun     <= ovr_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: randomized scans of mux_scan_ctrl against a frame-level
// model; a second instance with a 2-bit frame counter covers wrapping.
module tb_mux_scan_ctrl;

  localparam int SC = 2;
  localparam int P  = SC + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start;
  logic       cont_mode;
  logic       frame_ready;
  logic [3:0] ch_mask;
  logic [3:0] ivec;

  logic       ya;
  logic       yb;
  logic       s1a;
  logic       s0a;
  logic       s1b;
  logic       s0b;
  logic [3:0] frame_a;
  logic [3:0] frame_b;
  logic       valid_a;
  logic       valid_b;
  logic       busy_a;
  logic       busy_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic       ovr_a;
  logic       ovr_b;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  // registered mux_4x1 models
  always @(posedge clk) ya <= ivec[{s1a, s0a}];
  always @(posedge clk) yb <= ivec[{s1b, s0b}];

  mux_scan_ctrl #(.SETTLE_CYC(SC), .FRAME_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cont_mode(cont_mode), .ch_mask(ch_mask), .y(ya),
    .s1(s1a), .s0(s0a), .frame(frame_a),
    .frame_valid(valid_a), .frame_ready(frame_ready),
    .busy(busy_a), .frame_cnt(cnt_a), .overrun(ovr_a)
  );

  mux_scan_ctrl #(.SETTLE_CYC(SC), .FRAME_CNT_W(2)) dut_w (
    .clk(clk), .reset(reset), .start(start),
    .cont_mode(cont_mode), .ch_mask(ch_mask), .y(yb),
    .s1(s1b), .s0(s0b), .frame(frame_b),
    .frame_valid(valid_b), .frame_ready(frame_ready),
    .busy(busy_b), .frame_cnt(cnt_b), .overrun(ovr_b)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; cont_mode = 1'b0;
    frame_ready = 1'b1; ch_mask = 4'b0; ivec = 4'b0;
    repeat (3) step();
    n_cmp++;
    if ({s1a, s0a, valid_a, busy_a, ovr_a, frame_a} !== 9'b0) begin
      n_err++;
      $display("FAIL reset_outs: got %b want 0",
               {s1a, s0a, valid_a, busy_a, ovr_a, frame_a});
    end
    n_cmp++;
    if (cnt_a !== 8'd0 || cnt_b !== 2'd0) begin
      n_err++;
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", cnt_a, cnt_b);
    end
    reset = 1'b1;
    exp_cnt = 0;
    step();
  endtask

  // one single-shot scan; mid-scan start/mask/ready noise must be ignored
  task automatic test_scan(input logic [3:0] m, input logic [3:0] iv,
                           input string tag);
    int q[$];
    int n;
    int lat;
    logic [3:0] want;
    logic [1:0] esel;
    for (int i = 0; i < 4; i++) if (m[i]) q.push_back(i);
    n = q.size();
    lat = n * P + 1;
    ch_mask = m; ivec = iv; start = 1'b1;
    frame_ready = 1'b1; cont_mode = 1'b0;
    for (int k = 0; k <= lat; k++) begin
      step();
      if (k < lat) begin
        start = 1'($urandom_range(0, 1));
        ch_mask = 4'($urandom);
        frame_ready = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
        frame_ready = 1'b1;
      end
      if (k < n * P) esel = 2'(q[k / P]);
      else if (k == n * P) esel = 2'(q[n - 1]);
      else esel = 2'd0;
      n_cmp++;
      if ({s1a, s0a, busy_a, valid_a} !==
          {esel, k < lat, k == lat}) begin
        n_err++;
        $display("FAIL %s_seq k=%0d: sel/busy/valid got %b want %b",
                 tag, k, {s1a, s0a, busy_a, valid_a},
                 {esel, k < lat, k == lat});
      end
    end
    want = iv & m;
    exp_cnt++;
    n_cmp++;
    if (frame_a !== want || frame_b !== want) begin
      n_err++;
      $display("FAIL %s_frame: got %b/%b want %b",
               tag, frame_a, frame_b, want);
    end
    n_cmp++;
    if (cnt_a !== 8'(exp_cnt) || cnt_b !== 2'(exp_cnt)
        || ovr_a !== 1'b0) begin
      n_err++;
      $display("FAIL %s_cnt: got %0d/%0d ovr %b want %0d/%0d ovr 0",
               tag, cnt_a, cnt_b, ovr_a, 8'(exp_cnt), 2'(exp_cnt));
    end
  endtask

  task automatic test_full_mask();
    test_scan(4'b1111, 4'b0010, "full");
  endtask

  task automatic test_sparse_and_zero();
    test_scan(4'b1010, 4'b1010, "sparse");
    ch_mask = 4'b0000; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({busy_a, s1a, s0a, valid_a} !== 4'b0 ||
          cnt_a !== 8'(exp_cnt)) begin
        n_err++;
        $display("FAIL zero_mask k=%0d: busy/sel/valid %b cnt %0d want 0 cnt %0d",
                 k, {busy_a, s1a, s0a, valid_a}, cnt_a, exp_cnt);
      end
      step();
    end
  endtask

  task automatic test_random_scans();
    logic [3:0] m;
    for (int r = 0; r < 8; r++) begin
      m = 4'($urandom_range(1, 15));
      test_scan(m, 4'($urandom), "rand");
      repeat (2) step();
    end
  endtask

  task automatic test_cont_overrun();
    logic [3:0] iv;
    logic [3:0] iv2;
    iv = 4'($urandom);
    iv2 = ~iv;
    frame_ready = 1'b1;
    step();
    ivec = iv; ch_mask = 4'b0001; cont_mode = 1'b1;
    frame_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    exp_cnt++;
    n_cmp++;
    if ({valid_a, frame_a, ovr_a} !== {1'b1, 3'b0, iv[0], 1'b0} ||
        cnt_a !== 8'(exp_cnt)) begin
      n_err++;
      $display("FAIL cont_first: valid/frame/ovr %b cnt %0d want %b cnt %0d",
               {valid_a, frame_a, ovr_a}, cnt_a,
               {1'b1, 3'b0, iv[0], 1'b0}, exp_cnt);
    end
    repeat (4) step();
    n_cmp++;
    if ({valid_a, frame_a, ovr_a, busy_a} !==
        {1'b1, 3'b0, iv[0], 1'b1, 1'b1} ||
        cnt_a !== 8'(exp_cnt)) begin
      n_err++;
      $display("FAIL cont_overrun: valid/frame/ovr/busy %b cnt %0d want %b cnt %0d",
               {valid_a, frame_a, ovr_a, busy_a}, cnt_a,
               {1'b1, 3'b0, iv[0], 1'b1, 1'b1}, exp_cnt);
    end
    ivec = iv2;
    frame_ready = 1'b1;
    step();
    n_cmp++;
    if ({valid_a, frame_a} !== {1'b0, 3'b0, iv[0]}) begin
      n_err++;
      $display("FAIL cont_accept: valid/frame %b want %b",
               {valid_a, frame_a}, {1'b0, 3'b0, iv[0]});
    end
    repeat (3) step();
    exp_cnt++;
    n_cmp++;
    if ({valid_a, frame_a} !== {1'b1, 3'b0, iv2[0]} ||
        cnt_a !== 8'(exp_cnt)) begin
      n_err++;
      $display("FAIL cont_reload: valid/frame %b cnt %0d want %b cnt %0d",
               {valid_a, frame_a}, cnt_a,
               {1'b1, 3'b0, iv2[0]}, exp_cnt);
    end
    cont_mode = 1'b0;
    step();
    repeat (3) step();
    exp_cnt++;
    n_cmp++;
    if ({valid_a, busy_a, ovr_a} !== 3'b101 ||
        cnt_a !== 8'(exp_cnt)) begin
      n_err++;
      $display("FAIL cont_stop: valid/busy/ovr %b cnt %0d want 101 cnt %0d",
               {valid_a, busy_a, ovr_a}, cnt_a, exp_cnt);
    end
    step();
    n_cmp++;
    if ({valid_a, busy_a, s1a, s0a} !== 4'b0) begin
      n_err++;
      $display("FAIL cont_idle: valid/busy/sel %b want 0000",
               {valid_a, busy_a, s1a, s0a});
    end
  endtask

  task automatic test_reset_midscan();
    logic bad;
    frame_ready = 1'b1;
    step();
    ivec = 4'($urandom); ch_mask = 4'b1111;
    cont_mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    n_cmp++;
    if ({s1a, s0a, busy_a} !== 3'b101) begin
      n_err++;
      $display("FAIL mid_pre: sel/busy %b want 101", {s1a, s0a, busy_a});
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if ({s1a, s0a, busy_a, valid_a, ovr_a, frame_a} !== 9'b0 ||
        cnt_a !== 8'd0 || cnt_b !== 2'd0) begin
      n_err++;
      $display("FAIL mid_reset: outs %b cnt %0d/%0d want 0",
               {s1a, s0a, busy_a, valid_a, ovr_a, frame_a}, cnt_a, cnt_b);
    end
    exp_cnt = 0;
    reset = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (valid_a || busy_a) bad = 1'b1;
    end
    n_cmp++;
    if (bad !== 1'b0) begin
      n_err++;
      $display("FAIL mid_quiet: got activity %b want 0", bad);
    end
    test_scan(4'b1111, 4'($urandom), "fresh");
  endtask

  task automatic test_cnt_wrap();
    logic [3:0] m;
    logic [3:0] iv;
    int per;
    reset = 1'b0;
    step();
    reset = 1'b1;
    exp_cnt = 0;
    m = 4'($urandom_range(1, 15));
    iv = 4'($urandom);
    per = $countones(m) * P + 1;
    ch_mask = m; ivec = iv; cont_mode = 1'b1;
    frame_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int f = 1; f <= 5; f++) begin
      repeat (per) step();
      exp_cnt = f;
      n_cmp++;
      if (cnt_b !== 2'(f % 4) || cnt_a !== 8'(f) ||
          valid_b !== 1'b1 || frame_b !== (iv & m) ||
          busy_b !== (f < 5)) begin
        n_err++;
        $display("FAIL wrap f=%0d: cnt %0d/%0d v %b fr %b busy %b want %0d/%0d v 1 fr %b busy %b",
                 f, cnt_b, cnt_a, valid_b, frame_b, busy_b,
                 f % 4, f, iv & m, f < 5);
      end
      if (f == 4) cont_mode = 1'b0;
    end
    step();
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_sparse_and_zero();
    test_random_scans();
    test_cont_overrun();
    test_random_scans();
    test_reset_midscan();
    test_cnt_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
